// File: rtl/neureka_bist_pkg.sv
// Shared types for the infeat buffer March C- BIST: element/state enums,
// the per-op descriptor and the March C- element table with lookup helpers.
package neureka_bist_pkg;

    typedef enum logic [2:0] {
        ELEM_0 = 3'd0,
        ELEM_1 = 3'd1,
        ELEM_2 = 3'd2,
        ELEM_3 = 3'd3,
        ELEM_4 = 3'd4,
        ELEM_5 = 3'd5
    } march_elem_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } bist_state_e;

    typedef struct packed {
        logic is_write;
        logic data;
        logic down;
    } march_op_t;

    typedef struct packed {
        logic      two_ops;
        march_op_t op0;
        march_op_t op1;
    } elem_desc_t;

    localparam march_op_t OP_W0_UP = '{is_write: 1'b1, data: 1'b0, down: 1'b0};
    localparam march_op_t OP_W1_UP = '{is_write: 1'b1, data: 1'b1, down: 1'b0};
    localparam march_op_t OP_R0_UP = '{is_write: 1'b0, data: 1'b0, down: 1'b0};
    localparam march_op_t OP_R1_UP = '{is_write: 1'b0, data: 1'b1, down: 1'b0};
    localparam march_op_t OP_W0_DN = '{is_write: 1'b1, data: 1'b0, down: 1'b1};
    localparam march_op_t OP_W1_DN = '{is_write: 1'b1, data: 1'b1, down: 1'b1};
    localparam march_op_t OP_R0_DN = '{is_write: 1'b0, data: 1'b0, down: 1'b1};
    localparam march_op_t OP_R1_DN = '{is_write: 1'b0, data: 1'b1, down: 1'b1};

    // March C-: up(w0) up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) up(r0).
    // Single-op elements repeat op0 in op1 so the table stays uniform.
    localparam elem_desc_t ELEM_TABLE [6] = '{
        '{1'b0, OP_W0_UP, OP_W0_UP},
        '{1'b1, OP_R0_UP, OP_W1_UP},
        '{1'b1, OP_R1_UP, OP_W0_UP},
        '{1'b1, OP_R0_DN, OP_W1_DN},
        '{1'b1, OP_R1_DN, OP_W0_DN},
        '{1'b0, OP_R0_UP, OP_R0_UP}
    };

    function automatic logic elem_two_ops(input march_elem_e e);
        return ELEM_TABLE[e].two_ops;
    endfunction

    function automatic logic elem_down(input march_elem_e e);
        return ELEM_TABLE[e].op0.down;
    endfunction

    function automatic logic op_is_write(input march_elem_e e, input logic idx);
        return idx ? ELEM_TABLE[e].op1.is_write : ELEM_TABLE[e].op0.is_write;
    endfunction

    function automatic logic op_data(input march_elem_e e, input logic idx);
        return idx ? ELEM_TABLE[e].op1.data : ELEM_TABLE[e].op0.data;
    endfunction

endpackage

// File: rtl/neureka_bist_checker.sv
// Read-data checker for the infeat buffer BIST: a READ_LATENCY-deep tag delay
// line, the all-0/all-1 comparator, the sticky fail flag and (when
// NEUREKA_INFEAT_BIST_FAIL_LOG_EN is defined) the first-failure log.
module neureka_bist_checker
    import neureka_bist_pkg::*;
#(
    parameter int ADDR_WIDTH   = 6,
    parameter int DATA_WIDTH   = 128,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  rd_valid_i,
    input  logic                  rd_exp_i,
    input  march_elem_e           rd_elem_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    input  logic [DATA_WIDTH-1:0] q_i,
    output logic                  fail_next_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [2:0]            fail_elem_o
);

    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [READ_LATENCY-1:0] exp_q, exp_d;
    logic                    fail_q, fail_d;
    logic                    mismatch;

    // The oldest tag lines up with the wrapper's read data for this cycle.
    assign mismatch    = vld_q[READ_LATENCY-1] &&
                         (q_i != {DATA_WIDTH{exp_q[READ_LATENCY-1]}});
    assign fail_next_o = fail_q | mismatch;

    // Shift the valid/expected tags; a clear flushes reads still in flight.
    always_comb begin
        vld_d    = vld_q;
        exp_d    = exp_q;
        vld_d[0] = rd_valid_i;
        exp_d[0] = rd_exp_i;
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            exp_d[i] = exp_q[i-1];
        end
        if (clr_i) begin
            vld_d = '0;
        end
        fail_d = clr_i ? 1'b0 : (fail_q | mismatch);
    end

    // Tag pipeline and sticky fail flag.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_q  <= '0;
            exp_q  <= '0;
            fail_q <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            exp_q  <= exp_d;
            fail_q <= fail_d;
        end
    end

`ifdef NEUREKA_INFEAT_BIST_FAIL_LOG_EN
    logic [ADDR_WIDTH-1:0] tag_addr_q [READ_LATENCY];
    logic [ADDR_WIDTH-1:0] tag_addr_d [READ_LATENCY];
    logic [2:0]            tag_elem_q [READ_LATENCY];
    logic [2:0]            tag_elem_d [READ_LATENCY];
    logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic [2:0]            fail_elem_q, fail_elem_d;

    // Carry address/element tags alongside the read and latch only the first miss.
    always_comb begin
        tag_addr_d    = tag_addr_q;
        tag_elem_d    = tag_elem_q;
        tag_addr_d[0] = rd_addr_i;
        tag_elem_d[0] = rd_elem_i;
        for (int i = 1; i < READ_LATENCY; i++) begin
            tag_addr_d[i] = tag_addr_q[i-1];
            tag_elem_d[i] = tag_elem_q[i-1];
        end
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        if (clr_i) begin
            fail_addr_d = '0;
            fail_elem_d = '0;
        end else if (mismatch && !fail_q) begin
            fail_addr_d = tag_addr_q[READ_LATENCY-1];
            fail_elem_d = tag_elem_q[READ_LATENCY-1];
        end
    end

    // Fail-log registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_addr_q[i] <= '0;
                tag_elem_q[i] <= '0;
            end
            fail_addr_q <= '0;
            fail_elem_q <= '0;
        end else begin
            tag_addr_q  <= tag_addr_d;
            tag_elem_q  <= tag_elem_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
        end
    end

    assign fail_addr_o = fail_addr_q;
    assign fail_elem_o = fail_elem_q;
`else
    logic unused_log_tags;
    assign unused_log_tags = ^{rd_elem_i, rd_addr_i};
    assign fail_addr_o     = '0;
    assign fail_elem_o     = '0;
`endif

endmodule

// File: rtl/neureka_infeat_buffer_bist_ctrl.sv
// March C- BIST controller for the latch-based infeat buffer SCM. Owns the
// wrapper's test port while busy, issues one op per cycle and reports
// done/pass. Optional first-failure logging: NEUREKA_INFEAT_BIST_FAIL_LOG_EN.
module neureka_infeat_buffer_bist_ctrl
    import neureka_bist_pkg::*;
#(
    parameter int ADDR_WIDTH   = 6,
    parameter int DATA_WIDTH   = 128,
    parameter int NUM_WORDS    = 64,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  clear_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  bist_o,
    output logic                  csn_t_o,
    output logic                  wen_t_o,
    output logic [ADDR_WIDTH-1:0] a_t_o,
    output logic [DATA_WIDTH-1:0] d_t_o,
    input  logic [DATA_WIDTH-1:0] q_t_i,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [2:0]            fail_elem_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
    localparam logic [1:0]            DRAIN_LAST = 2'(READ_LATENCY - 1);

    bist_state_e           state_q, state_d;
    march_elem_e           elem_q, elem_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  op_idx_q, op_idx_d;
    logic [1:0]            drain_q, drain_d;
    logic                  busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic                  bist_q, bist_d, csn_q, csn_d, wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] d_q, d_d;
    logic                  issue, chk_clr, chk_fail_next, cur_down, at_last, nxt_wr;
    logic                  rd_valid;

    // Counters track the op on the port this cycle; the next op is decoded and registered.
    always_comb begin
        state_d  = state_q;
        elem_d   = elem_q;
        addr_d   = addr_q;
        op_idx_d = op_idx_q;
        drain_d  = drain_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        csn_d    = 1'b1;
        wen_d    = 1'b1;
        a_d      = '0;
        d_d      = '0;
        issue    = 1'b0;
        chk_clr  = 1'b0;
        nxt_wr   = 1'b0;
        cur_down = elem_down(elem_q);
        at_last  = cur_down ? (addr_q == '0) : (addr_q == LAST_ADDR);

        if (clear_i) begin
            state_d  = ST_IDLE;
            elem_d   = ELEM_0;
            addr_d   = '0;
            op_idx_d = 1'b0;
            drain_d  = '0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            pass_d   = 1'b0;
            chk_clr  = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state_d  = ST_RUN;
                        elem_d   = ELEM_0;
                        addr_d   = '0;
                        op_idx_d = 1'b0;
                        busy_d   = 1'b1;
                        done_d   = 1'b0;
                        pass_d   = 1'b0;
                        chk_clr  = 1'b1;
                        issue    = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (elem_two_ops(elem_q) && !op_idx_q) begin
                        op_idx_d = 1'b1;
                        issue    = 1'b1;
                    end else begin
                        op_idx_d = 1'b0;
                        if (!at_last) begin
                            addr_d = cur_down ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
                            issue  = 1'b1;
                        end else if (elem_q == ELEM_5) begin
                            state_d = ST_DRAIN;
                            drain_d = '0;
                        end else begin
                            elem_d = march_elem_e'(elem_q + 3'd1);
                            addr_d = elem_down(elem_d) ? LAST_ADDR : '0;
                            issue  = 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == DRAIN_LAST) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = ~chk_fail_next;
                    end else begin
                        drain_d = drain_q + 2'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        bist_d = busy_d;
        if (issue) begin
            nxt_wr = op_is_write(elem_d, op_idx_d);
            csn_d  = 1'b0;
            wen_d  = ~nxt_wr;
            a_d    = addr_d;
            d_d    = nxt_wr ? {DATA_WIDTH{op_data(elem_d, op_idx_d)}} : '0;
        end
    end

    // Controller state, counters and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            elem_q   <= ELEM_0;
            addr_q   <= '0;
            op_idx_q <= 1'b0;
            drain_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            bist_q   <= 1'b0;
            csn_q    <= 1'b1;
            wen_q    <= 1'b1;
            a_q      <= '0;
            d_q      <= '0;
        end else begin
            state_q  <= state_d;
            elem_q   <= elem_d;
            addr_q   <= addr_d;
            op_idx_q <= op_idx_d;
            drain_q  <= drain_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            bist_q   <= bist_d;
            csn_q    <= csn_d;
            wen_q    <= wen_d;
            a_q      <= a_d;
            d_q      <= d_d;
        end
    end

    assign rd_valid = (state_q == ST_RUN) && !op_is_write(elem_q, op_idx_q);

    neureka_bist_checker #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_checker (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (chk_clr),
        .rd_valid_i (rd_valid),
        .rd_exp_i   (op_data(elem_q, op_idx_q)),
        .rd_elem_i  (elem_q),
        .rd_addr_i  (addr_q),
        .q_i        (q_t_i),
        .fail_next_o(chk_fail_next),
        .fail_addr_o(fail_addr_o),
        .fail_elem_o(fail_elem_o)
    );

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign pass_o  = pass_q;
    assign bist_o  = bist_q;
    assign csn_t_o = csn_q;
    assign wen_t_o = wen_q;
    assign a_t_o   = a_q;
    assign d_t_o   = d_q;

endmodule

// File: tb/tb_neureka_infeat_buffer_bist_ctrl.sv
// Testbench for neureka_infeat_buffer_bist_ctrl: behavioural SCM models with
// injectable faults, a table of fault scenarios, and directed sequences for
// clear, reset, start-while-busy and a NUM_WORDS=40/READ_LATENCY=2 instance.
module tb_neureka_infeat_buffer_bist_ctrl;

    localparam int AW   = 6;
    localparam int DW   = 128;
    localparam int NW   = 64;
    localparam int NW_B = 40;
`ifdef NEUREKA_INFEAT_BIST_FAIL_LOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start, clear, start_b;
    logic          busy, done, pass, bist, csn, wen;
    logic [AW-1:0] a, faddr;
    logic [DW-1:0] d, q;
    logic [2:0]    felem;
    logic          busy_b, done_b, pass_b, bist_b, csn_b, wen_b;
    logic [AW-1:0] a_b, faddr_b;
    logic [DW-1:0] d_b, q_b, q1_b;
    logic [2:0]    felem_b;

    logic [DW-1:0] mem   [NW];
    logic [DW-1:0] mem_b [NW];
    logic [AW-1:0] op_addr   [NW*10];
    logic          op_wr     [NW*10];
    logic [AW-1:0] op_addr_b [NW_B*10];
    logic [DW-1:0] d65;
    int            op_cnt, wr_cnt, op_cnt_b, max_addr_b;
    int            tests, failures;

    bit            sa_en, cf_en;
    int            sa_addr, sa_bit;
    logic          sa_val;

    neureka_infeat_buffer_bist_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .clear_i(clear),
        .busy_o(busy), .done_o(done), .pass_o(pass), .bist_o(bist),
        .csn_t_o(csn), .wen_t_o(wen), .a_t_o(a), .d_t_o(d), .q_t_i(q),
        .fail_addr_o(faddr), .fail_elem_o(felem)
    );

    neureka_infeat_buffer_bist_ctrl #(
        .NUM_WORDS(NW_B), .READ_LATENCY(2)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .clear_i(1'b0),
        .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b), .bist_o(bist_b),
        .csn_t_o(csn_b), .wen_t_o(wen_b), .a_t_o(a_b), .d_t_o(d_b), .q_t_i(q_b),
        .fail_addr_o(faddr_b), .fail_elem_o(felem_b)
    );

    function automatic logic [DW-1:0] faulty(input logic [DW-1:0] w, input logic [AW-1:0] addr);
        logic [DW-1:0] r;
        r = w;
        if (sa_en && int'(addr) == sa_addr) r[sa_bit] = sa_val;
        return r;
    endfunction

    // SCM model for the default instance, latency 1, with stuck-at and coupling faults
    always @(posedge clk) begin
        if (bist && !csn) begin
            if (op_cnt < NW*10) begin
                op_addr[op_cnt] = a;
                op_wr[op_cnt]   = !wen;
            end
            if (op_cnt == 65) d65 = d;
            op_cnt = op_cnt + 1;
            if (!wen) begin
                wr_cnt = wr_cnt + 1;
                mem[a] <= d;
                if (cf_en && a == AW'(5)) mem[4] <= d;
            end else begin
                q <= faulty(mem[a], a);
            end
        end
    end

    // SCM model for the 40-word instance, latency 2
    always @(posedge clk) begin
        q_b <= q1_b;
        if (bist_b && !csn_b) begin
            if (op_cnt_b < NW_B*10) op_addr_b[op_cnt_b] = a_b;
            if (int'(a_b) > max_addr_b) max_addr_b = int'(a_b);
            op_cnt_b = op_cnt_b + 1;
            if (!wen_b) mem_b[a_b] <= d_b;
            else        q1_b       <= mem_b[a_b];
        end
    end

    task automatic applyStimulus(input logic s, input logic c);
        @(negedge clk);
        start = s;
        clear = c;
    endtask

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Start a test, optionally re-pulse start at cycle pulse_at, wait (bounded) for done
    task automatic waitDone(input int pulse_at, output int done_cycle,
                            output logic busy_c1, output logic bist_pre, output logic bist_done);
        applyStimulus(1'b1, 1'b0);
        done_cycle = -1;
        busy_c1    = 1'b0;
        bist_pre   = 1'b0;
        bist_done  = 1'b1;
        for (int c = 1; c <= 1500; c++) begin
            @(posedge clk);
            #1;
            start = (c == pulse_at);
            if (c == 1)   busy_c1  = busy & bist;
            if (c == 641) bist_pre = bist & busy & !done;
            if (done) begin
                done_cycle = c;
                bist_done  = bist;
                break;
            end
        end
        start = 1'b0;
    endtask

    typedef struct {
        string name;
        bit    sa_en;
        int    sa_addr;
        int    sa_bit;
        logic  sa_val;
        bit    cf_en;
        logic  exp_pass;
        int    exp_faddr;
        int    exp_felem;
    } vec_t;

    vec_t vecs [6];
    int   done_cyc;
    logic busy1, bist_pre, bist_done;

    initial begin
        tests = 0; failures = 0;
        rst_n = 1'b0; start = 1'b0; clear = 1'b0; start_b = 1'b0;
        sa_en = 1'b0; cf_en = 1'b0; sa_addr = 0; sa_bit = 0; sa_val = 1'b0;
        op_cnt = 0; wr_cnt = 0; op_cnt_b = 0; max_addr_b = 0;
        q = '0; q_b = '0; q1_b = '0; d65 = '0;

        vecs[0] = '{"fault_free",   1'b0, 0,    0,   1'b0, 1'b0, 1'b1, 0,    0};
        vecs[1] = '{"sa1_b17_2a",   1'b1, 42,   17,  1'b1, 1'b0, 1'b0, 42,   1};
        vecs[2] = '{"cf_5_to_4",    1'b0, 0,    0,   1'b0, 1'b1, 1'b0, 4,    3};
        vecs[3] = '{"sa0_b0_00",    1'b1, 0,    0,   1'b0, 1'b0, 1'b0, 0,    2};
        vecs[4] = '{"sa0_b127_3f",  1'b1, 63,   127, 1'b0, 1'b0, 1'b0, 63,   2};
        vecs[5] = '{"rerun_clean",  1'b0, 0,    0,   1'b0, 1'b0, 1'b1, 0,    0};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_pass", pass, 0);
        checkOutput("rst_bist", bist, 0);
        checkOutput("rst_csn", csn, 1);
        checkOutput("rst_wen", wen, 1);
        checkOutput("rst_addr", a, 0);
        checkOutput("rst_data", d, 0);
        checkOutput("rst_faddr", faddr, 0);
        checkOutput("rst_felem", felem, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            sa_en = vecs[i].sa_en; sa_addr = vecs[i].sa_addr; sa_bit = vecs[i].sa_bit;
            sa_val = vecs[i].sa_val; cf_en = vecs[i].cf_en;
            op_cnt = 0; wr_cnt = 0;
            waitDone(0, done_cyc, busy1, bist_pre, bist_done);
            checkOutput($sformatf("%s/done_cycle", vecs[i].name), done_cyc, 642);
            checkOutput($sformatf("%s/pass", vecs[i].name), pass, vecs[i].exp_pass);
            checkOutput($sformatf("%s/busy_at_done", vecs[i].name), busy, 0);
            checkOutput($sformatf("%s/fail_addr", vecs[i].name), faddr, LOG_EN ? vecs[i].exp_faddr : 0);
            checkOutput($sformatf("%s/fail_elem", vecs[i].name), felem, LOG_EN ? vecs[i].exp_felem : 0);
            if (i == 0) begin
                checkOutput("ops_issued", op_cnt, 640);
                checkOutput("writes_issued", wr_cnt, 320);
                checkOutput("busy_cycle1", busy1, 1);
                checkOutput("bist_in_drain", bist_pre, 1);
                checkOutput("bist_low_at_done", bist_done, 0);
                checkOutput("op0_addr", op_addr[0], 0);
                checkOutput("op0_is_write", op_wr[0], 1);
                checkOutput("op65_w1_data", d65, {DW{1'b1}});
                checkOutput("op320_down_start", op_addr[320], 63);
                checkOutput("op322_down_next", op_addr[322], 62);
                checkOutput("op639_addr", op_addr[639], 63);
                checkOutput("op639_is_read", op_wr[639], 0);
            end
        end
        sa_en = 1'b0; cf_en = 1'b0;

        // start pulsed at cycle 100 while busy must not disturb timing
        waitDone(100, done_cyc, busy1, bist_pre, bist_done);
        checkOutput("busy_start/done_cycle", done_cyc, 642);
        checkOutput("busy_start/pass", pass, 1);

        // clear at cycle 300, then a fresh run
        applyStimulus(1'b1, 1'b0);
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        checkOutput("clear/bist", bist, 0);
        checkOutput("clear/busy", busy, 0);
        checkOutput("clear/done", done, 0);
        checkOutput("clear/csn", csn, 1);
        waitDone(0, done_cyc, busy1, bist_pre, bist_done);
        checkOutput("after_clear/done_cycle", done_cyc, 642);
        checkOutput("after_clear/pass", pass, 1);

        // clear wins over start in the same cycle; also clears done/pass
        applyStimulus(1'b1, 1'b1);
        @(posedge clk);
        #1;
        start = 1'b0; clear = 1'b0;
        checkOutput("clr_prio/busy", busy, 0);
        checkOutput("clr_prio/bist", bist, 0);
        checkOutput("clr_prio/done", done, 0);
        checkOutput("clr_prio/pass", pass, 0);

        // reset mid-test
        applyStimulus(1'b1, 1'b0);
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        checkOutput("midrst/bist_before", bist, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midrst/bist", bist, 0);
        checkOutput("midrst/busy", busy, 0);
        checkOutput("midrst/csn", csn, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // NUM_WORDS=40, READ_LATENCY=2 instance
        op_cnt_b = 0; max_addr_b = 0; done_cyc = -1;
        @(negedge clk);
        start_b = 1'b1;
        for (int c = 1; c <= 1000; c++) begin
            @(posedge clk);
            #1;
            start_b = 1'b0;
            if (done_b) begin
                done_cyc = c;
                break;
            end
        end
        checkOutput("b/done_cycle", done_cyc, 403);
        checkOutput("b/pass", pass_b, 1);
        checkOutput("b/ops", op_cnt_b, 400);
        checkOutput("b/max_addr", max_addr_b, 39);
        checkOutput("b/down_start", op_addr_b[200], 39);
        checkOutput("b/down_next", op_addr_b[202], 38);
        checkOutput("b/last_addr", op_addr_b[399], 39);
        checkOutput("b/fail_addr", faddr_b, 0);
        checkOutput("b/fail_elem", felem_b, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
